// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU output packer.
package ppu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO between the byte packer and the GLB write port.
// Read data comes straight from the storage registers, so the head entry is valid the cycle after it is pushed.
module packer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // NOTE: the storage is reset because its head entry drives the write-data output,
    // which must read 0 out of reset; at this depth the cost is negligible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ppu_out_packer.sv
// Packs the PPU byte stream little-endian into 32-bit GLB writes with auto-incrementing addresses.
// Define PACKER_WSTRB_EN to carry per-lane strobes for a partial last word; otherwise out_wstrb is 4'hF.
module ppu_out_packer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_bytes,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic [3:0]        out_wstrb,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef PACKER_WSTRB_EN
    localparam int FIFO_W = WORD_W + WORD_BYTES;
`else
    localparam int FIFO_W = WORD_W;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_bytes_left;
    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_merged;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_push;
    logic              w_pop;
    logic [FIFO_W-1:0] w_push_data;
    logic [FIFO_W-1:0] w_rd_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = (r_bytes_left == 16'd1);
    assign w_push      = w_accept && (w_last_byte || r_lane == LANE_W'(WORD_BYTES - 1));
    assign w_pop       = out_valid && out_ready;

    always_comb begin
        w_word_merged                            = r_word;
        w_word_merged[r_lane * BYTE_W +: BYTE_W] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (cfg_num_bytes == 16'd0) ? DONE : PACK;
            end
            PACK: begin
                busy     = 1'b1;
                in_ready = !w_fifo_full;
                if (w_accept && w_last_byte) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (w_fifo_empty || (w_pop && w_fifo_count == CNT_W'(1))) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Job config is captured only on an accepted start, so later cfg changes cannot disturb a job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_bytes_left <= '0;
            r_lane       <= '0;
            r_word       <= '0;
        end else if (r_state == IDLE && start) begin
            r_addr       <= cfg_base_addr;
            r_bytes_left <= cfg_num_bytes;
            r_lane       <= '0;
            r_word       <= '0;
        end else begin
            if (w_pop) r_addr <= r_addr + ADDR_W'(WORD_BYTES);
            if (w_accept) begin
                r_bytes_left <= r_bytes_left - 16'd1;
                if (w_push) begin
                    r_lane <= '0;
                    r_word <= '0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_word <= w_word_merged;
                end
            end
        end
    end

`ifdef PACKER_WSTRB_EN
    logic [WORD_BYTES-1:0] r_strb;
    logic [WORD_BYTES-1:0] w_strb_merged;

    always_comb begin
        w_strb_merged         = r_strb;
        w_strb_merged[r_lane] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         r_strb <= '0;
        else if (r_state == IDLE && start) r_strb <= '0;
        else if (w_push)                  r_strb <= '0;
        else if (w_accept)                r_strb <= w_strb_merged;
    end

    assign w_push_data = {w_strb_merged, w_word_merged};
    assign out_wstrb   = out_valid ? w_rd_data[FIFO_W-1 -: WORD_BYTES] : 4'h0;
`else
    assign w_push_data = w_word_merged;
    assign out_wstrb   = out_valid ? 4'hF : 4'h0;
`endif

    packer_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign out_addr  = r_addr;
    assign out_data  = w_rd_data[WORD_W-1:0];

endmodule

// File: doc/ppu_out_packer.md
# ppu_out_packer

Downstream of the post-processing unit: accepts the stream of 8-bit quantised (optionally ReLU'd / max-pooled) results, packs four bytes little-endian into 32-bit words, buffers them in a small FIFO and writes them to the global buffer through a valid/ready write port with auto-incrementing addresses. One job per `start` pulse writes exactly `cfg_num_bytes` bytes; a trailing partial word is zero-padded and flagged. It decouples PPU throughput from GLB write back-pressure.

## Interface
- `FIFO_DEPTH`, 4: word-FIFO entries (power of two, ≥2)
- `ADDR_W`, 32: GLB byte-address width
- `clk` input 1: clock
- `rst` input 1: reset, asynchronous, active-low (asserted at 0)
- `start` input 1: one-cycle job start; sampled only in IDLE
- `cfg_base_addr` input ADDR_W: first word address (4-byte aligned), sampled on `start`
- `cfg_num_bytes` input 16: bytes in job, sampled on `start`
- `in_valid` input 1: PPU byte valid
- `in_data` input 8: PPU byte (`data_out` of PPU)
- `in_ready` output 1: byte accepted when `in_valid && in_ready`
- `out_valid` output 1: GLB write request
- `out_ready` input 1: GLB accepts word
- `out_addr` output ADDR_W: word byte-address
- `out_data` output 32: packed word
- `out_wstrb` output 4: byte enables
- `busy` output 1: high in PACK/FLUSH
- `done` output 1: one-cycle pulse at job end

## Operation
- States: IDLE → PACK on `start` (if `cfg_num_bytes`≠0) or → DONE (if 0). PACK → FLUSH when last byte accepted. FLUSH → DONE when FIFO empty and last word handshaken. DONE → IDLE after one cycle (`done`=1 there only).
- `start` outside IDLE ignored; config registers frozen during a job.
- Lane counter 0..3: byte k of a word goes to bits [8k+7:8k]; first byte of job at lane 0.
- Word pushed to FIFO when lane 3 accepted, or when the job's last byte accepted (partial word). Unfilled lanes = 0; strobe bit set per filled lane.
- `in_ready` = PACK && FIFO not full. Byte counter decrements on each accepted byte.
- Address counter starts at `cfg_base_addr`, +4 per output handshake; wraps modulo 2^ADDR_W.
- FIFO pop on `out_valid && out_ready`; `out_*` stable while `out_valid && !out_ready`.
- Push and pop in the same cycle permitted when not full; push blocked when full (via `in_ready`), no simultaneous push-on-full.

## Timing
- Reset: state IDLE, FIFO empty, lane/counters 0, `in_ready`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_wstrb`=0, `busy`=0, `done`=0.
- Reset mid-job: job aborted, buffered words discarded, no `done`.
- `start` at cycle t → `busy`/`in_ready` high at t+1.
- Completing byte accepted at t → `out_valid` high at t+1 (FIFO registered, 1-cycle latency) if FIFO was empty.
- Sustained throughput: 1 byte/cycle in, 1 word per 4 cycles out when `out_ready`=1.
- Last word handshake at t → DONE at t+1 (`done`=1, `busy`=0) → IDLE at t+2; a new `start` is accepted at t+2.
- `cfg_num_bytes`=0: `start` at t → `done` at t+1, no writes.

## Configuration
- `PACKER_WSTRB_EN`: defined → `out_wstrb` reflects filled lanes of partial last word (e.g. 3 bytes → 4'b0111). Undefined → `out_wstrb` constant 4'hF whenever `out_valid`, padding bytes still 0; strobe storage removed from FIFO. Reset value 0 in both cases.

## Structure
- Shared package `ppu_pkg`: state enum (IDLE, PACK, FLUSH, DONE), `WORD_BYTES`=4, `BYTE_W`=8.
- Sub-module `packer_fifo`: synchronous FIFO, parameter width/depth, registered read data, `full`/`empty`, same reset.

## Test plan
- Base 0x100, 8 bytes 0x01..0x08, `out_ready`=1 → two writes: 0x100/0x04030201, 0x104/0x08070605, wstrb 4'hF, `done` one cycle after second handshake.
- 6 bytes 0xA0..0xA5 → second write 0x104 data 0x0000A5A4, wstrb 4'b0011 (4'hF without `PACKER_WSTRB_EN`).
- `out_ready`=0 for 40 cycles, 32 bytes offered → `in_ready` drops after 16 bytes (4 words), outputs held stable; release → all 8 words in order, addresses +4.
- `cfg_num_bytes`=0 → `done` at t+1, `out_valid` never high.
- Reset asserted after 5 bytes of a 12-byte job → all outputs 0 immediately; new job afterwards starts at lane 0 and correct base.
- `start` pulsed during PACK → ignored; byte count and address unchanged.
